// File: rtl/tpu_drain_pkg.sv
// ---------------------------------------------------------------------------
// tpu_drain_pkg
// Shared types and constants for the TPU result drain.
//   drain_state_t : drain FSM state encoding (IDLE / DRAIN)
//   LANE_W        : lane index width for the default 9-lane build
// ---------------------------------------------------------------------------
package tpu_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int NUM_UNITS_DEF = 9;
  localparam int LANE_W        = $clog2(NUM_UNITS_DEF);

endpackage

// File: rtl/tpu_result_drain_if.sv
// ---------------------------------------------------------------------------
// tpu_result_drain_if
// Valid/ready result stream carrying one lane value per beat.
//   m_valid : beat valid                 (master -> slave)
//   m_ready : downstream ready           (slave  -> master)
//   m_data  : lane value                 (master -> slave)
//   m_index : result index in the frame  (master -> slave)
//   m_last  : last result of the frame   (master -> slave)
// ---------------------------------------------------------------------------
interface tpu_result_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [IDX_W-1:0]      m_index;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/lane_next_picker.sv
// ---------------------------------------------------------------------------
// lane_next_picker
// Combinational search for the lowest set mask bit strictly above `lane`.
// `lane` is signed one bit wider than a lane number, so all-ones (-1) asks
// for the first set lane of the mask.
//   mask      : lane enable mask
//   lane      : current lane (signed, -1 = before lane 0)
//   next_lane : lowest set lane above `lane` (0 when none_left)
//   none_left : no set lane above `lane`
// ---------------------------------------------------------------------------
module lane_next_picker #(
  parameter int NUM_UNITS = 9,
  parameter int LW        = 4
) (
  input  logic [NUM_UNITS-1:0] mask,
  input  logic [LW:0]          lane,
  output logic [LW-1:0]        next_lane,
  output logic                 none_left
);

  // Scan downwards so the lowest qualifying lane is the one that sticks.
  always_comb begin
    next_lane = {LW{1'b0}};
    none_left = 1'b1;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (mask[i] && ($signed({1'b0, LW'(i)}) > $signed(lane))) begin
        next_lane = LW'(i);
        none_left = 1'b0;
      end else begin
        next_lane = next_lane;
        none_left = none_left;
      end
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// ---------------------------------------------------------------------------
// tpu_result_drain
// Captures the TPU lane vector on the rising edge of `done` and serializes
// the enabled lanes, lowest first, onto a valid/ready stream with a running
// result index that wraps at RESULT_COUNT.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-low
//   done         : TPU completion level (rising edge = capture event)
//   relu_out     : packed lane results [NUM_UNITS-1:0][DATA_WIDTH-1:0]
//   active_units : lane enable mask, sampled at capture
//   frame_start  : one-cycle pulse, clears index and overflow
//   m            : result stream (master modport)
//   busy         : high while draining (or a capture is pending)
//   overflow     : sticky, a capture event was dropped
//   frame_done   : one-cycle pulse after the beat carrying m_last
//
// Build option: define TPU_DRAIN_DOUBLE_BUF_EN to add a single pending
// capture slot that absorbs one capture event arriving mid-drain.
// ---------------------------------------------------------------------------
module tpu_result_drain
  import tpu_drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_UNITS    = 9,
  parameter int RESULT_COUNT = 9,
  parameter int IDX_W        = $clog2(RESULT_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 done,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] relu_out,
  input  logic [NUM_UNITS-1:0]                 active_units,
  input  logic                                 frame_start,
  tpu_result_drain_if.master                   m,
  output logic                                 busy,
  output logic                                 overflow,
  output logic                                 frame_done
);

  localparam int LW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [0:0]       S_IDLE   = IDLE;
  localparam logic [0:0]       S_DRAIN  = DRAIN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESULT_COUNT - 1);

  logic [0:0]                           state_r;
  logic                                 done_q_r;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] cap_data_r;
  logic [NUM_UNITS-1:0]                 cap_mask_r;
  logic [LW-1:0]                        lane_r;
  logic [IDX_W-1:0]                     index_r;
  logic                                 m_valid_r;
  logic [DATA_WIDTH-1:0]                m_data_r;
  logic                                 m_last_r;
  logic                                 busy_r;
  logic                                 overflow_r;
  logic                                 frame_done_r;

  logic                                 xfer_s;
  logic                                 cap_evt_s;
  logic                                 final_xfer_s;
  logic                                 window_s;
  logic                                 load_s;
  logic                                 drop_s;
  logic                                 pend_nxt_s;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] src_data_s;
  logic [NUM_UNITS-1:0]                 src_mask_s;
  logic [LW-1:0]                        cur_next_s;
  logic                                 cur_none_s;
  logic [LW-1:0]                        first_lane_s;
  logic                                 first_none_s;
  logic [0:0]                           state_nxt_s;
  logic                                 valid_nxt_s;
  logic [LW-1:0]                        lane_nxt_s;
  logic [DATA_WIDTH-1:0]                data_nxt_s;
  logic [IDX_W-1:0]                     index_nxt_s;
  logic                                 overflow_nxt_s;

  assign m.m_valid  = m_valid_r;
  assign m.m_data   = m_data_r;
  assign m.m_index  = index_r;
  assign m.m_last   = m_last_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign frame_done = frame_done_r;

  // Next lane after the one currently on the stream.
  lane_next_picker #(.NUM_UNITS(NUM_UNITS), .LW(LW)) u_pick_cur (
    .mask      (cap_mask_r),
    .lane      ({1'b0, lane_r}),
    .next_lane (cur_next_s),
    .none_left (cur_none_s)
  );

  // First lane of whatever is about to be loaded (lane = -1).
  lane_next_picker #(.NUM_UNITS(NUM_UNITS), .LW(LW)) u_pick_first (
    .mask      (src_mask_s),
    .lane      ({(LW + 1){1'b1}}),
    .next_lane (first_lane_s),
    .none_left (first_none_s)
  );

  // Handshake, edge detect and capture window.
  always_comb begin
    xfer_s       = m_valid_r & m.m_ready;
    cap_evt_s    = done & ~done_q_r;
    final_xfer_s = (state_r == S_DRAIN) & xfer_s & cur_none_s;
    // Capture is accepted when idle, or when the final beat leaves this
    // cycle so the next vector follows with no bubble.
    window_s     = (state_r == S_IDLE) | final_xfer_s;
  end

`ifdef TPU_DRAIN_DOUBLE_BUF_EN
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] pend_data_r;
  logic [NUM_UNITS-1:0]                 pend_mask_r;
  logic                                 pend_valid_r;
  logic                                 unload_s;
  logic                                 direct_s;
  logic                                 fill_s;

  // Route captures through the pending slot; the slot is older than any
  // same-cycle capture event, so it is always loaded first.
  always_comb begin
    unload_s = window_s & pend_valid_r;
    direct_s = cap_evt_s & window_s & ~pend_valid_r;
    fill_s   = cap_evt_s & ~direct_s & (~pend_valid_r | unload_s);
    drop_s   = cap_evt_s & ~direct_s & pend_valid_r & ~unload_s;
    load_s   = direct_s | unload_s;
    if (pend_valid_r) begin
      src_data_s = pend_data_r;
      src_mask_s = pend_mask_r;
    end else begin
      src_data_s = relu_out;
      src_mask_s = active_units;
    end
    if (fill_s) begin
      pend_nxt_s = 1'b1;
    end else if (unload_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_valid_r;
    end
  end

  // Pending capture slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_valid_r <= 1'b0;
      pend_data_r  <= '0;
      pend_mask_r  <= {NUM_UNITS{1'b0}};
    end else begin
      pend_valid_r <= pend_nxt_s;
      if (fill_s) begin
        pend_data_r <= relu_out;
        pend_mask_r <= active_units;
      end
    end
  end
`else
  // Single-buffered: capture only inside the window, drop otherwise.
  always_comb begin
    src_data_s = relu_out;
    src_mask_s = active_units;
    load_s     = window_s & cap_evt_s;
    drop_s     = cap_evt_s & ~window_s;
    pend_nxt_s = 1'b0;
  end
`endif

  // Drain FSM: load a new vector, step to the next set lane, or go idle.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = m_valid_r;
    lane_nxt_s  = lane_r;
    data_nxt_s  = m_data_r;
    if (load_s) begin
      if (!first_none_s) begin
        state_nxt_s = S_DRAIN;
        valid_nxt_s = 1'b1;
        lane_nxt_s  = first_lane_s;
        data_nxt_s  = src_data_s[first_lane_s];
      end else begin
        // Empty mask: nothing to send, index untouched.
        state_nxt_s = S_IDLE;
        valid_nxt_s = 1'b0;
      end
    end else if (xfer_s && (state_r == S_DRAIN)) begin
      if (!cur_none_s) begin
        lane_nxt_s = cur_next_s;
        data_nxt_s = cap_data_r[cur_next_s];
      end else begin
        state_nxt_s = S_IDLE;
        valid_nxt_s = 1'b0;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Result index and sticky overflow; frame_start wins over an increment.
  always_comb begin
    if (frame_start) begin
      index_nxt_s = {IDX_W{1'b0}};
    end else if (xfer_s) begin
      if (index_r == LAST_IDX) begin
        index_nxt_s = {IDX_W{1'b0}};
      end else begin
        index_nxt_s = index_r + IDX_W'(1);
      end
    end else begin
      index_nxt_s = index_r;
    end
    if (frame_start) begin
      overflow_nxt_s = 1'b0;
    end else if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      done_q_r     <= 1'b0;
      cap_data_r   <= '0;
      cap_mask_r   <= {NUM_UNITS{1'b0}};
      lane_r       <= {LW{1'b0}};
      index_r      <= {IDX_W{1'b0}};
      m_valid_r    <= 1'b0;
      m_data_r     <= {DATA_WIDTH{1'b0}};
      m_last_r     <= 1'b0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      done_q_r     <= done;
      state_r      <= state_nxt_s;
      m_valid_r    <= valid_nxt_s;
      lane_r       <= lane_nxt_s;
      m_data_r     <= data_nxt_s;
      index_r      <= index_nxt_s;
      // m_last follows the index alone, not the lane position.
      m_last_r     <= (index_nxt_s == LAST_IDX);
      overflow_r   <= overflow_nxt_s;
      frame_done_r <= xfer_s & m_last_r;
      busy_r       <= (state_nxt_s == S_DRAIN) | pend_nxt_s;
      if (load_s) begin
        cap_data_r <= src_data_s;
        cap_mask_r <= src_mask_s;
      end
    end
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// ---------------------------------------------------------------------------
// tb_tpu_result_drain
// Directed, table-driven bench for tpu_result_drain plus hand-written
// sequences for overflow, back-to-back capture, empty mask and reset.
// ---------------------------------------------------------------------------
module tb_tpu_result_drain;

  logic             clk = 1'b0;
  logic             reset;
  logic             done;
  logic [8:0][15:0] relu;
  logic [8:0]       active;
  logic             frame_start;
  logic             busy;
  logic             overflow;
  logic             frame_done;

  tpu_result_drain_if #(.DATA_WIDTH(16), .IDX_W(4)) sif ();

  tpu_result_drain #(.DATA_WIDTH(16), .NUM_UNITS(9), .RESULT_COUNT(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .done         (done),
    .relu_out     (relu),
    .active_units (active),
    .frame_start  (frame_start),
    .m            (sif),
    .busy         (busy),
    .overflow     (overflow),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  idx;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  // lanes: nibble k = lane number of beat k (hand-written)
  typedef struct packed {
    logic [8:0]      mask;
    logic [3:0]      n;
    logic [8:0][3:0] lanes;
    logic            rmode;
    logic [3:0]      fd_off;
  } vec_t;

  vec_t  tbl [6];
  beat_t beats [$];

  int n_vec = 0;
  int n_err = 0;
  bit rmode = 1'b0;
  int rcnt = 0;
  bit valid_seen = 1'b0;
  int first_valid_cyc = 0;
  int fd_cnt = 0;
  int fd_cyc = 0;
  bit stall_chk_en = 1'b0;
  int stall_seen = 0;
  int stall_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rmode) begin
      sif.m_ready = (rcnt % 3 == 0);
      rcnt++;
    end
  endtask

  task automatic set_relu(input logic [15:0] base);
    for (int k = 0; k < 9; k++) relu[k] = base + 16'(k);
  endtask

  task automatic clear_obs();
    beats.delete();
    valid_seen = 1'b0;
    fd_cnt = 0;
    stall_seen = 0;
    stall_bad = 0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Observer: records every handshake and checks stability during stalls.
  initial begin
    bit          prev_stall = 1'b0;
    logic [15:0] prev_d = 16'h0;
    logic [3:0]  prev_i = 4'h0;
    logic        prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.m_valid && !valid_seen) begin
        valid_seen = 1'b1;
        first_valid_cyc = cyc;
      end
      if (sif.m_valid && sif.m_ready)
        beats.push_back('{d: sif.m_data, idx: sif.m_index, last: sif.m_last, cyc: 32'(cyc)});
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (stall_chk_en && prev_stall) begin
        stall_seen++;
        if (!sif.m_valid || sif.m_data !== prev_d || sif.m_index !== prev_i || sif.m_last !== prev_l)
          stall_bad++;
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_d = sif.m_data;
      prev_i = sif.m_index;
      prev_l = sif.m_last;
    end
  end

  initial begin
    int  t0;
    int  exp_beats;
    int  exp_lasts;
    int  lasts;
    int  nb;
    bit  got;
    vec_t v;

    tbl[0] = '{mask: 9'h1FF, n: 4'd9, lanes: 36'h876543210, rmode: 1'b0, fd_off: 4'd10};
    tbl[1] = '{mask: 9'h105, n: 4'd3, lanes: 36'h000000820, rmode: 1'b0, fd_off: 4'd0};
    tbl[2] = '{mask: 9'h001, n: 4'd1, lanes: 36'h000000000, rmode: 1'b0, fd_off: 4'd0};
    tbl[3] = '{mask: 9'h100, n: 4'd1, lanes: 36'h000000008, rmode: 1'b0, fd_off: 4'd0};
    tbl[4] = '{mask: 9'h0AA, n: 4'd4, lanes: 36'h000007531, rmode: 1'b0, fd_off: 4'd0};
    tbl[5] = '{mask: 9'h1FF, n: 4'd9, lanes: 36'h876543210, rmode: 1'b1, fd_off: 4'd0};

    // ---- reset state ----
    reset = 1'b0;
    done = 1'b0;
    frame_start = 1'b0;
    active = 9'h1FF;
    sif.m_ready = 1'b1;
    set_relu(16'h3C00);
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_valid", 32'(sif.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_m_index", 32'(sif.m_index), 32'd0);
    chk("rst_m_last", 32'(sif.m_last), 32'd0);
    reset = 1'b1;
    step();

    // ---- table-driven single-capture drains ----
    for (int k = 0; k < 6; k++) begin
      v = tbl[k];
      active = v.mask;
      pulse_frame_start();
      clear_obs();
      rmode = v.rmode;
      rcnt = 0;
      stall_chk_en = v.rmode;
      t0 = cyc;
      done = 1'b1;
      step();
      done = 1'b0;
      repeat (39) step();
      rmode = 1'b0;
      stall_chk_en = 1'b0;
      sif.m_ready = 1'b1;
      step();
      chk($sformatf("v%0d_beats", k), 32'(beats.size()), 32'(v.n));
      for (int i = 0; i < int'(v.n) && i < beats.size(); i++) begin
        chk($sformatf("v%0d_b%0d_data", k, i), 32'(beats[i].d), 32'(16'h3C00 + 16'(v.lanes[i])));
        chk($sformatf("v%0d_b%0d_index", k, i), 32'(beats[i].idx), 32'(i));
        chk($sformatf("v%0d_b%0d_last", k, i), 32'(beats[i].last), 32'(i == 8));
      end
      if (v.n != 4'd0) chk($sformatf("v%0d_latency", k), 32'(first_valid_cyc), 32'(t0 + 1));
      chk($sformatf("v%0d_frame_done_cnt", k), 32'(fd_cnt), 32'(v.n == 4'd9));
      if (v.fd_off != 4'd0) begin
        chk($sformatf("v%0d_last_beat_cyc", k), beats[beats.size()-1].cyc, 32'(t0 + 9));
        chk($sformatf("v%0d_frame_done_cyc", k), 32'(fd_cyc), 32'(t0 + int'(v.fd_off)));
      end
      if (v.rmode) begin
        chk($sformatf("v%0d_stall_hold_errs", k), 32'(stall_bad), 32'd0);
        chk($sformatf("v%0d_stalls_seen", k), 32'(stall_seen > 0), 32'd1);
      end
      chk($sformatf("v%0d_overflow", k), 32'(overflow), 32'd0);
      chk($sformatf("v%0d_busy_end", k), 32'(busy), 32'd0);
    end

    // ---- overflow: second done edge mid-drain ----
`ifdef TPU_DRAIN_DOUBLE_BUF_EN
    exp_beats = 18;
    exp_lasts = 2;
`else
    exp_beats = 9;
    exp_lasts = 1;
`endif
    active = 9'h1FF;
    pulse_frame_start();
    clear_obs();
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (40) step();
    chk("ovf_beats", 32'(beats.size()), 32'(exp_beats));
    lasts = 0;
    for (int i = 0; i < beats.size() && i < exp_beats; i++) begin
      chk($sformatf("ovf_b%0d_data", i), 32'(beats[i].d), 32'(16'h3C00 + 16'(i % 9)));
      chk($sformatf("ovf_b%0d_index", i), 32'(beats[i].idx), 32'(i % 9));
      if (beats[i].last) lasts++;
    end
    chk("ovf_last_cnt", 32'(lasts), 32'(exp_lasts));
    chk("ovf_frame_done_cnt", 32'(fd_cnt), 32'(exp_lasts));
`ifdef TPU_DRAIN_DOUBLE_BUF_EN
    chk("ovf_flag", 32'(overflow), 32'd0);
`else
    chk("ovf_flag", 32'(overflow), 32'd1);
`endif
    pulse_frame_start();
    @(negedge clk);
    chk("ovf_cleared_by_frame_start", 32'(overflow), 32'd0);

    // ---- back-to-back capture on the final handshake ----
    active = 9'h003;
    set_relu(16'h3C00);
    pulse_frame_start();
    clear_obs();
    t0 = cyc;
    done = 1'b1;
    step();
    done = 1'b0;
    set_relu(16'h3D00);
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (20) step();
    chk("b2b_beats", 32'(beats.size()), 32'd4);
    if (beats.size() == 4) begin
      chk("b2b_b0_data", 32'(beats[0].d), 32'h3C00);
      chk("b2b_b1_data", 32'(beats[1].d), 32'h3C01);
      chk("b2b_b2_data", 32'(beats[2].d), 32'h3D00);
      chk("b2b_b3_data", 32'(beats[3].d), 32'h3D01);
      chk("b2b_b3_index", 32'(beats[3].idx), 32'd3);
      chk("b2b_no_bubble", beats[2].cyc, beats[1].cyc + 32'd1);
      chk("b2b_b3_cyc", beats[3].cyc, 32'(t0 + 4));
    end
    chk("b2b_overflow", 32'(overflow), 32'd0);

    // ---- empty mask: no beats, index unchanged (4) ----
    clear_obs();
    active = 9'h000;
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (10) step();
    chk("empty_beats", 32'(beats.size()), 32'd0);
    chk("empty_valid_seen", 32'(valid_seen), 32'd0);
    chk("empty_index_kept", 32'(sif.m_index), 32'd4);
    chk("empty_busy", 32'(busy), 32'd0);

    // ---- reset in the middle of a drain ----
    active = 9'h1FF;
    set_relu(16'h3C00);
    pulse_frame_start();
    clear_obs();
    done = 1'b1;
    step();
    done = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (beats.size() >= 3) got = 1'b1;
    end
    chk("rstmid_reach_beat4", 32'(got), 32'd1);
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("rstmid_m_valid", 32'(sif.m_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_index", 32'(sif.m_index), 32'd0);
    chk("rstmid_overflow", 32'(overflow), 32'd0);
    nb = beats.size();
    reset = 1'b1;
    repeat (5) step();
    chk("rstmid_no_more_beats", 32'(beats.size()), 32'(nb));
    clear_obs();
    done = 1'b1;
    step();
    done = 1'b0;
    repeat (30) step();
    chk("rstmid_redrain_beats", 32'(beats.size()), 32'd9);
    for (int i = 0; i < beats.size() && i < 9; i++) begin
      chk($sformatf("rstmid_b%0d_data", i), 32'(beats[i].d), 32'(16'h3C00 + 16'(i)));
      chk($sformatf("rstmid_b%0d_index", i), 32'(beats[i].idx), 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tpu_result_drain.md
Name: tpu_result_drain

Overview:
- Reader side of the TPU result interface: captures the per-unit `relu_out` vector when `done` rises.
- Serializes the lanes enabled in `active_units`, lowest first, onto a valid/ready stream, tagging each beat with its running result index.
- Sits between `tensor_processing_unit` and the result store or host port, in place of the bench polling `done` and reading `relu_out` directly.

Parameters:
- DATA_WIDTH, 16, width of one result lane.
- NUM_UNITS, 9, number of parallel lanes in `relu_out`.
- RESULT_COUNT, 9, results per frame; for 5x5 input and 3x3 kernel this is 3x3.
- IDX_W, $clog2(RESULT_COUNT), width of `m_index`.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; block held in reset while 0.
- done  in  1  TPU completion level.
- relu_out  in  NUM_UNITS*DATA_WIDTH  TPU lane results, packed [NUM_UNITS-1:0][DATA_WIDTH-1:0].
- active_units  in  NUM_UNITS  lane enable mask, sampled at capture.
- frame_start  in  1  one-cycle pulse; clears index and overflow.
- m_ready  in  1  downstream ready.
- m_valid  out  1  beat valid.
- m_data  out  DATA_WIDTH  lane value.
- m_index  out  IDX_W  result index within the frame.
- m_last  out  1  high on the beat with m_index == RESULT_COUNT-1.
- busy  out  1  high in DRAIN.
- overflow  out  1  sticky; a capture was dropped.
- frame_done  out  1  one-cycle pulse after the last beat of a frame.

Behaviour:
- Reset (reset==0 at a clk edge) clears all outputs to 0 and sets state IDLE, index 0, done_q 0. This applies mid-drain: the in-flight beat is abandoned with no further beats.
- Edge detect: done_q <= done; capture event = done & ~done_q.
- Capture window: state IDLE, or DRAIN with the final beat handshaking this cycle (back-to-back support).
- On capture: latch relu_out into cap_data and active_units into cap_mask.
  - If mask != 0, go to DRAIN.
  - If mask == 0, stay IDLE with no beats and no index change.
- Capture event outside the window: dropped and overflow <= 1.
- Latency: done rises at edge N, so m_valid=1 from edge N+1 with the lowest set lane.
- States:
  - IDLE -> DRAIN on a capture with nonzero mask.
  - DRAIN -> DRAIN while set lanes remain above the current lane.
  - DRAIN -> IDLE on the handshake of the last set lane, unless a back-to-back capture occurs.
- Handshake:
  - Transfer = m_valid & m_ready.
  - m_data, m_index and m_last hold stable while m_valid & ~m_ready.
  - m_valid never drops without a transfer, except on reset.
- Index:
  - Increments on each transfer.
  - On the transfer with m_last=1, index wraps to 0 and frame_done pulses on the next cycle.
  - Lanes not set in cap_mask consume no index.
- frame_start:
  - Index <= 0, overflow <= 0.
  - Takes priority over a same-cycle increment.
  - Does not abort the drain; the current beat's m_index becomes 0.
- m_last is derived from index only, independent of lane position. A frame may span several captures, or end mid-capture and continue from index 0.

Optional Feature:
- Macro TPU_DRAIN_DOUBLE_BUF_EN.
- Defined: adds one pending slot (data+mask+valid).
  - A capture event during DRAIN outside the window fills the slot.
  - On drain completion, the slot is loaded with no idle cycle, i.e. as if captured at that edge.
  - overflow sets only if the slot is already full.
  - busy stays high while the slot is valid.
- Undefined: no slot; behaviour exactly as above.

Decomposition:
- Package tpu_drain_pkg:
  - state enum drain_state_t {IDLE, DRAIN}.
  - lane index width constant LANE_W = $clog2(NUM_UNITS) for the default build, plus a localparam recomputed in the module.
- Sub-module lane_next_picker:
  - Purely combinational.
  - Given mask and current lane, returns the next set lane above it and a none-left flag; also used with lane = -1 for the first lane.
- Drain FSM, index counter and capture registers stay in the top module.

Test Plan:
- All lanes active: active_units=9'h1FF, lane k = 16'h3C00+k, m_ready=1, done rises at edge N -> beats at N+1..N+9 carry 3C00..3C08 with m_index 0..8; m_last on the 9th beat; frame_done at N+10; busy low from N+10.
- Sparse mask: active_units=9'b100000101 -> exactly 3 beats, lanes 0, 2, 8, with m_index 0, 1, 2 and m_last=0.
- Backpressure: m_ready toggles 1,0,0,1,... -> no beat lost or duplicated; outputs constant during stalls; 9 beats total.
- Overflow (macro undefined): second done edge during the 3rd beat -> overflow=1 and only 9 beats; frame_start clears it. With the macro defined, the same stimulus yields 18 beats; index wraps and m_last fires twice.
- Back-to-back and empty mask:
  - done edge on the last handshake -> next capture drains with no bubble, index continues.
  - active_units=0 -> no m_valid, index unchanged.
- Reset mid-drain: reset=0 at the 4th beat -> next cycle m_valid=0, busy=0, index 0, overflow 0; a later done edge drains normally from index 0.
